// File: rtl/lcd_dieu_khien.sv
// 20x4 HD44780 character-LCD driver: power-up wait, init sequence, then frame refresh from a row snapshot.
// Optional: define LCD_DIEU_KHIEN_ON_CHANGE_EN to start frames only when the row inputs differ from the snapshot.

module lcd_dieu_khien #(
    parameter int unsigned E_HIGH_CYC     = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000,
    parameter int unsigned POWERUP_CYC    = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [159:0] lcd_h0,
    input  logic [159:0] lcd_h1,
    input  logic [159:0] lcd_h2,
    input  logic [159:0] lcd_h3,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_db,
    output logic         init_done,
    output logic         frame_done
);

    localparam int unsigned MAX_EC  = (E_HIGH_CYC > CMD_WAIT_CYC) ? E_HIGH_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_PC  = (CLEAR_WAIT_CYC > POWERUP_CYC) ? CLEAR_WAIT_CYC : POWERUP_CYC;
    localparam int unsigned MAX_CYC = (MAX_EC > MAX_PC) ? MAX_EC : MAX_PC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned ROW_W   = 160;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_SNAP,
        ST_ROW_ADDR,
        ST_ROW_DATA
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    state_e                    state_q;
    phase_e                    phase_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [1:0]                init_idx_q;
    logic [1:0]                row_q;
    logic [4:0]                col_q;
    logic [3:0][ROW_W-1:0]     snap_q;
    logic                      lcd_e_q;
    logic                      lcd_rs_q;
    logic [7:0]                lcd_db_q;
    logic                      init_done_q;
    logic                      frame_done_q;
`ifdef LCD_DIEU_KHIEN_ON_CHANGE_EN
    logic                      first_q;
`endif

    logic                      pwr_last_c;
    logic                      strobe_last_c;
    logic                      hold_last_c;
    logic                      start_frame_c;
    logic [3:0][ROW_W-1:0]     rows_c;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Set-DDRAM-address command for the first cell of each panel row.
    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    function automatic logic [7:0] char_at(input logic [3:0][ROW_W-1:0] s,
                                           input logic [1:0] row,
                                           input logic [4:0] col);
        return s[row][159 - 8*int'(col) -: 8];
    endfunction

    assign rows_c        = {lcd_h3, lcd_h2, lcd_h1, lcd_h0};
    assign pwr_last_c    = (cnt_q == CNT_W'(POWERUP_CYC - 1));
    assign strobe_last_c = (cnt_q == CNT_W'(E_HIGH_CYC - 1));
    // The clear command needs the long wait; everything else uses the normal command wait.
    assign hold_last_c   = (state_q == ST_INIT && init_idx_q == 2'd3)
                         ? (cnt_q == CNT_W'(CLEAR_WAIT_CYC - 1))
                         : (cnt_q == CNT_W'(CMD_WAIT_CYC - 1));
`ifdef LCD_DIEU_KHIEN_ON_CHANGE_EN
    assign start_frame_c = first_q || (rows_c != snap_q);
`else
    assign start_frame_c = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PWR_WAIT;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            init_idx_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            snap_q       <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_db_q     <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_DIEU_KHIEN_ON_CHANGE_EN
            first_q      <= 1'b1;
`endif
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_PWR_WAIT: begin
                    if (pwr_last_c) begin
                        cnt_q      <= '0;
                        state_q    <= ST_INIT;
                        phase_q    <= PH_SETUP;
                        init_idx_q <= 2'd0;
                        lcd_rs_q   <= 1'b0;
                        lcd_db_q   <= init_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_SNAP: begin
                    if (start_frame_c) begin
                        snap_q   <= rows_c;
                        state_q  <= ST_ROW_ADDR;
                        phase_q  <= PH_SETUP;
                        row_q    <= 2'd0;
                        cnt_q    <= '0;
                        lcd_rs_q <= 1'b0;
                        lcd_db_q <= row_cmd(2'd0);
`ifdef LCD_DIEU_KHIEN_ON_CHANGE_EN
                        first_q  <= 1'b0;
`endif
                    end
                end

                ST_INIT, ST_ROW_ADDR, ST_ROW_DATA: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q <= PH_STROBE;
                            cnt_q   <= '0;
                            lcd_e_q <= 1'b1;
                        end

                        PH_STROBE: begin
                            if (strobe_last_c) begin
                                phase_q <= PH_HOLD;
                                cnt_q   <= '0;
                                lcd_e_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end

                        PH_HOLD: begin
                            if (!hold_last_c) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end else begin
                                // Write finished: pick the next write or hand over to SNAP.
                                cnt_q   <= '0;
                                phase_q <= PH_SETUP;
                                if (state_q == ST_INIT) begin
                                    if (init_idx_q == 2'd3) begin
                                        init_done_q <= 1'b1;
                                        state_q     <= ST_SNAP;
                                    end else begin
                                        init_idx_q <= init_idx_q + 2'd1;
                                        lcd_db_q   <= init_cmd(init_idx_q + 2'd1);
                                    end
                                end else if (state_q == ST_ROW_ADDR) begin
                                    state_q  <= ST_ROW_DATA;
                                    col_q    <= 5'd0;
                                    lcd_rs_q <= 1'b1;
                                    lcd_db_q <= char_at(snap_q, row_q, 5'd0);
                                end else if (col_q != 5'd19) begin
                                    col_q    <= col_q + 5'd1;
                                    lcd_db_q <= char_at(snap_q, row_q, col_q + 5'd1);
                                end else if (row_q != 2'd3) begin
                                    state_q  <= ST_ROW_ADDR;
                                    row_q    <= row_q + 2'd1;
                                    lcd_rs_q <= 1'b0;
                                    lcd_db_q <= row_cmd(row_q + 2'd1);
                                end else begin
                                    frame_done_q <= 1'b1;
                                    state_q      <= ST_SNAP;
                                end
                            end
                        end

                        default: begin
                            phase_q <= PH_SETUP;
                            lcd_e_q <= 1'b0;
                        end
                    endcase
                end

                default: begin
                    state_q <= ST_PWR_WAIT;
                    phase_q <= PH_SETUP;
                    cnt_q   <= '0;
                    lcd_e_q <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_db     = lcd_db_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_dieu_khien.sv
// Directed bench for lcd_dieu_khien with a small HD44780 panel model latching on the falling edge of lcd_e.
// Covers init, full frame, snapshot stability, strobe-phase reset and the mode-specific refresh behaviour.

module tb_lcd_dieu_khien;

    localparam int unsigned E_HIGH     = 2;
    localparam int unsigned CMD_WAIT   = 5;
    localparam int unsigned CLEAR_WAIT = 20;
    localparam int unsigned PWR        = 10;

    localparam logic [159:0] ROW_TXT = "  Dong Ho The Thao  ";
    localparam logic [159:0] ROW_A   = {20{8'h41}};
    localparam logic [159:0] ROW_B   = {20{8'h42}};
    localparam logic [159:0] ROW_C   = {20{8'h43}};
    localparam logic [159:0] ROW_Z   = {20{8'h5A}};

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] lcd_h0, lcd_h1, lcd_h2, lcd_h3;
    logic         lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_db;
    logic         init_done, frame_done;

    always #5 clk = ~clk;

    lcd_dieu_khien #(
        .E_HIGH_CYC     (E_HIGH),
        .CMD_WAIT_CYC   (CMD_WAIT),
        .CLEAR_WAIT_CYC (CLEAR_WAIT),
        .POWERUP_CYC    (PWR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_h0     (lcd_h0),
        .lcd_h1     (lcd_h1),
        .lcd_h2     (lcd_h2),
        .lcd_h3     (lcd_h3),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_db     (lcd_db),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Panel model: DDRAM plus address counter, command log for non-address commands.
    logic [7:0] ddram [128];
    logic [6:0] ac;
    logic [7:0] cmd_log [8];
    int         n_cmd;

    always @(negedge lcd_e) begin
        if (rst === 1'b0) begin
            if (!lcd_rs) begin
                if (lcd_db[7]) begin
                    ac = lcd_db[6:0];
                end else begin
                    if (n_cmd < 8) cmd_log[n_cmd] = lcd_db;
                    n_cmd++;
                    if (lcd_db == 8'h01) begin
                        for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
                        ac = 7'd0;
                    end
                end
            end else begin
                ddram[ac] = lcd_db;
                ac = ac + 7'd1;
            end
        end
    end

    function automatic logic [159:0] panel_row(input logic [6:0] base);
        logic [159:0] r;
        for (int i = 0; i < 20; i++) r[159 - 8*i -: 8] = ddram[base + 7'(i)];
        return r;
    endfunction

    // Strobe shape monitor: every lcd_e pulse lasts E_HIGH cycles with rs/db steady.
    int         e_run = 0;
    int         strobe_bad = 0;
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = '0;

    always @(negedge clk) begin
        if (rst) begin
            e_run  = 0;
            prev_e = 1'b0;
        end else begin
            if (lcd_e) begin
                e_run++;
                if (prev_e && prev_bus != {lcd_rs, lcd_db}) strobe_bad++;
            end else if (e_run != 0) begin
                if (e_run != int'(E_HIGH)) strobe_bad++;
                e_run = 0;
            end
            prev_e   = lcd_e;
            prev_bus = {lcd_rs, lcd_db};
        end
    end

    // Called right after reset release on a falling clock edge.
    task automatic do_init(input string tag);
        logic [7:0] exp_cmd [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        int n       = 0;
        int first_e = 0;
        while (!init_done && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (lcd_e && first_e == 0) first_e = n;
        end
        check_eq({tag, "_latency"}, 160'(n), 160'(57));
        check_eq({tag, "_first_strobe"}, 160'(first_e), 160'(11));
        check_eq({tag, "_cmd_count"}, 160'(n_cmd), 160'(4));
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_cmd%0d", tag, i), 160'(cmd_log[i]), 160'(exp_cmd[i]));
    endtask

    // Counts edges to the next frame_done; optionally swaps lcd_h2 to Z mid-frame.
    task automatic wait_frame(input int start, input int change_at, output int m);
        m = start;
        do begin
            @(posedge clk);
            #1;
            m++;
            if (m == change_at) lcd_h2 = ROW_Z;
        end while (!frame_done && m < 2000);
    endtask

    int           m;
    int           start;
    int           e_hi;
    logic         found;
    logic [159:0] row3_exp;

    initial begin
        rst    = 1'b1;
        lcd_h0 = ROW_TXT;
        lcd_h1 = ROW_A;
        lcd_h2 = ROW_B;
        lcd_h3 = ROW_C;
        n_cmd  = 0;
        ac     = 7'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 160'({lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, frame_done}), 160'(0));
        rst = 1'b0;

        do_init("init1");

        wait_frame(0, -1, m);
        check_eq("frame1_len", 160'(m), 160'(673));
        check_eq("frame1_row0", panel_row(7'h00), ROW_TXT);
        check_eq("frame1_row1", panel_row(7'h40), ROW_A);
        check_eq("frame1_row2", panel_row(7'h14), ROW_B);
        check_eq("frame1_row3", panel_row(7'h54), ROW_C);

`ifdef LCD_DIEU_KHIEN_ON_CHANGE_EN
        e_hi = 0;
        repeat (2000) begin
            @(posedge clk);
            #1;
            if (lcd_e) e_hi++;
        end
        check_eq("idle_e_high", 160'(e_hi), 160'(0));
        @(negedge clk);
        lcd_h3[0] = ~lcd_h3[0];
        row3_exp  = lcd_h3;
        @(posedge clk);
        #1;
        check_eq("change_setup", 160'({lcd_e, lcd_rs, lcd_db}), 160'({1'b0, 1'b0, 8'h80}));
        start = 1;
`else
        row3_exp = ROW_C;
        start    = 0;
`endif

        wait_frame(start, 200, m);
        check_eq("frame2_len", 160'(m), 160'(673));
        check_eq("frame2_row2_snap", panel_row(7'h14), ROW_B);
        check_eq("frame2_row3", panel_row(7'h54), row3_exp);

        wait_frame(0, -1, m);
        check_eq("frame3_len", 160'(m), 160'(673));
        check_eq("frame3_row2", panel_row(7'h14), ROW_Z);
        @(posedge clk);
        #1;
        check_eq("frame_done_pulse", 160'(frame_done), 160'(0));

        // Reset in the middle of a data strobe.
        lcd_h0 = ROW_A;
        found  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (lcd_e && lcd_rs) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("strobe_found", 160'(found), 160'(1));
        rst = 1'b1;
        #1;
        check_eq("strobe_rst_e", 160'(lcd_e), 160'(0));
        check_eq("strobe_rst_outputs", 160'({lcd_e, lcd_rs, lcd_rw, lcd_db, init_done, frame_done}), 160'(0));
        n_cmd = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_init("init2");

        check_eq("strobe_shape", 160'(strobe_bad), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
